// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared constants for the ring-buffered Ethernet receiver
package eth_rx_pkg;

    localparam int MAC_LEN = 6;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    localparam logic [7:0] REG_STATUS   = 8'd0;
    localparam logic [7:0] REG_DROP_CNT = 8'd1;
    localparam logic [7:0] REG_LEN_LO   = 8'd2;
    localparam logic [7:0] REG_LEN_HI   = 8'd3;
    localparam logic [7:0] REG_CTRL     = 8'd4;

    localparam int ST_FULL     = 0;
    localparam int ST_ALL_FULL = 1;
    localparam int ST_DROP     = 2;
    localparam int ST_BUSY     = 3;

    // Header byte idx of an address; byte 0 is the first one on the wire.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int idx);
        if (idx < 0 || idx >= MAC_LEN) return 8'h00;
        return mac[47 - 8*idx -: 8];
    endfunction

endpackage

// File: rtl/eth_spi_byte_rx.sv
// rtl/eth_spi_byte_rx.sv - link synchronisers, bit shifter and byte strobe
module eth_spi_byte_rx (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sck,
    input  logic       i_mosi,
    input  logic       i_n_ss,
    output logic [7:0] o_byte,
    output logic       o_byte_stb,
    output logic       o_frame_start,
    output logic       o_frame_end,
    output logic       o_busy
);

    logic [2:0] r_sck_s;
    logic [2:0] r_ss_s;
    logic [1:0] r_mosi_s;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_stb;
    logic       w_sck_rise;

    // Bit 2 of each sync chain is history only, used for edge detection.
    assign w_sck_rise    = r_sck_s[1] & ~r_sck_s[2];
    assign o_frame_start = r_ss_s[2] & ~r_ss_s[1];
    assign o_frame_end   = ~r_ss_s[2] & r_ss_s[1];
    assign o_busy        = ~r_ss_s[1];
    assign o_byte        = r_shift;
    assign o_byte_stb    = r_stb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sck_s   <= 3'b000;
            r_ss_s    <= 3'b111;
            r_mosi_s  <= 2'b00;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_stb     <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], i_sck};
            r_ss_s   <= {r_ss_s[1:0], i_n_ss};
            r_mosi_s <= {r_mosi_s[0], i_mosi};
            r_stb    <= 1'b0;
            if (r_ss_s[1]) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[6:0], r_mosi_s[1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_stb     <= (r_bit_cnt == 3'd7);
            end
        end
    end

endmodule

// File: rtl/eth_rx_ring.sv
// rtl/eth_rx_ring.sv - MAC filter, ring of frame slots and CPU register/buffer window
module eth_rx_ring
    import eth_rx_pkg::*;
#(
    parameter int          SLOTS    = 2,
    parameter int          SLOT_AW  = 11,
    parameter logic [47:0] MAC      = 48'h02_00_00_00_00_01,
    parameter logic [15:0] REG_BASE = 16'hFB00,
    parameter logic [15:0] BUF_BASE = 16'hF000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_recv_sck,
    input  logic        i_recv_mosi,
    input  logic        i_n_recv_ss,
    input  logic [15:0] i_a,
    input  logic [7:0]  i_d_i,
    output logic [7:0]  o_d_o,
    output logic        o_d_oe,
    input  logic        i_n_we,
    input  logic        i_n_oe,
    output logic        o_n_rdy
);

    localparam int PW    = $clog2(SLOTS);
    localparam int DEPTH = 1 << SLOT_AW;
    localparam int LW    = SLOT_AW + 1;

    logic [7:0] w_byte;
    logic       w_byte_stb, w_frame_start, w_frame_end, w_busy;

    eth_spi_byte_rx u_byte_rx (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_sck         (i_recv_sck),
        .i_mosi        (i_recv_mosi),
        .i_n_ss        (i_n_recv_ss),
        .o_byte        (w_byte),
        .o_byte_stb    (w_byte_stb),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end),
        .o_busy        (w_busy)
    );

    logic [PW-1:0]    r_wr, r_rd;
    logic [SLOTS-1:0] r_full;
    logic [LW-1:0]    r_len [SLOTS];
    logic [LW-1:0]    r_cnt;
    logic             r_capture, r_reject, r_ovf, r_uc_ok, r_bc_ok;
    logic [7:0]       r_drop_cnt;
    logic             r_drop_sticky, r_promisc;
    logic             r_nwe_d, r_noe_d;
    logic [15:0]      r_a_d;
    logic [7:0]       r_ram [SLOTS*DEPTH];
    logic [7:0]       r_buf_data;

    logic             w_reg_sel, w_buf_sel, w_we, w_pop, w_clr_sticky, w_ctrl_we;
    logic             w_store, w_room, w_hdr, w_uc_nx, w_bc_nx, w_commit, w_drop;
    logic [7:0]       w_off, w_reg_data;
    logic [LW-1:0]    w_len_rd;

    assign w_reg_sel    = (i_a[15:8] == REG_BASE[15:8]);
    assign w_buf_sel    = (i_a[15:SLOT_AW] == BUF_BASE[15:SLOT_AW]);
    assign w_off        = i_a[7:0];
    assign w_we         = r_nwe_d & ~i_n_we & w_reg_sel;
    assign w_pop        = w_we && (w_off == REG_STATUS) && i_d_i[ST_FULL] && r_full[r_rd];
    assign w_clr_sticky = w_we && (w_off == REG_STATUS) && i_d_i[ST_DROP];
    assign w_ctrl_we    = w_we && (w_off == REG_CTRL);

    assign w_store = r_capture && w_byte_stb && !r_reject && !r_ovf;
    assign w_room  = (r_cnt < LW'(DEPTH));
    assign w_hdr   = (r_cnt < LW'(MAC_LEN));
    assign w_uc_nx = r_uc_ok && (!w_hdr || w_byte == mac_byte(MAC, int'(r_cnt)));
    assign w_bc_nx = r_bc_ok && (!w_hdr || w_byte == mac_byte(BCAST_MAC, int'(r_cnt)));

    assign w_commit = w_frame_end && r_capture && !r_reject && !r_ovf && (r_cnt >= LW'(MAC_LEN));
    // Filter rejects are not drops; only ring-full, overflow and runt frames count.
    assign w_drop   = (w_frame_start && r_full[r_wr]) ||
                      (w_frame_end && r_capture && !r_reject && (r_ovf || !(r_cnt >= LW'(MAC_LEN))));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_capture <= 1'b0;
            r_cnt     <= '0;
            r_reject  <= 1'b0;
            r_ovf     <= 1'b0;
            r_uc_ok   <= 1'b1;
            r_bc_ok   <= 1'b1;
        end else if (w_frame_start) begin
            r_capture <= !r_full[r_wr];
            r_cnt     <= '0;
            r_reject  <= 1'b0;
            r_ovf     <= 1'b0;
            r_uc_ok   <= 1'b1;
            r_bc_ok   <= 1'b1;
        end else if (w_frame_end) begin
            r_capture <= 1'b0;
        end else if (w_store) begin
            if (!w_room) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + LW'(1);
                r_uc_ok <= w_uc_nx;
                r_bc_ok <= w_bc_nx;
                if (!r_promisc && !w_uc_nx && !w_bc_nx) r_reject <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr          <= '0;
            r_rd          <= '0;
            r_full        <= '0;
            r_drop_cnt    <= 8'h00;
            r_drop_sticky <= 1'b0;
            r_promisc     <= 1'b0;
            r_nwe_d       <= 1'b1;
            r_noe_d       <= 1'b1;
            r_a_d         <= 16'h0000;
            for (int i = 0; i < SLOTS; i++) r_len[i] <= '0;
        end else begin
            if (w_pop) r_rd <= r_rd + PW'(1);
            if (w_commit) begin
                r_wr        <= r_wr + PW'(1);
                r_len[r_wr] <= r_cnt;
            end
            for (int i = 0; i < SLOTS; i++) begin
                if (w_commit && r_wr == PW'(i)) r_full[i] <= 1'b1;
                else if (w_pop && r_rd == PW'(i)) r_full[i] <= 1'b0;
            end
            if (w_drop) begin
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
                r_drop_sticky <= 1'b1;
            end else if (w_clr_sticky) begin
                r_drop_sticky <= 1'b0;
            end
            if (w_ctrl_we) r_promisc <= i_d_i[0];
            r_nwe_d <= i_n_we;
            r_noe_d <= i_n_oe;
            r_a_d   <= i_a;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_store && w_room) r_ram[{r_wr, r_cnt[SLOT_AW-1:0]}] <= w_byte;
        r_buf_data <= r_ram[{r_rd, i_a[SLOT_AW-1:0]}];
    end

    assign w_len_rd = r_len[r_rd];

    always_comb begin
        w_reg_data = 8'h00;
        case (w_off)
            REG_STATUS:   w_reg_data = {4'b0000, w_busy, r_drop_sticky, &r_full, r_full[r_rd]};
            REG_DROP_CNT: w_reg_data = r_drop_cnt;
            REG_LEN_LO:   w_reg_data = w_len_rd[7:0];
            REG_LEN_HI:   w_reg_data = 8'(w_len_rd >> 8);
            REG_CTRL:     w_reg_data = {7'b0000000, r_promisc};
            default:      w_reg_data = 8'h00;
        endcase
    end

    // Window data is one registered RAM read behind the address, hence one wait cycle.
    assign o_d_oe  = (w_reg_sel || w_buf_sel) && !i_n_oe;
    assign o_d_o   = !o_d_oe ? 8'h00 : (w_reg_sel ? w_reg_data : r_buf_data);
    assign o_n_rdy = w_buf_sel && !w_reg_sel && !i_n_oe && (r_noe_d || (i_a != r_a_d));

endmodule
